// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared mode encoding and truncation-depth clamp for the approximate multiplier
package approx_mul_pkg;
   typedef enum logic [1:0] {
      MODE_EXACT = 2'b00,
      MODE_TRUNC = 2'b01,
      MODE_COMP  = 2'b10
   } mode_e;

   function automatic int clamp_k(input int k, input int width);
      return (k > 2 * width - 1) ? 2 * width - 1 : k;
   endfunction
endpackage

// File: rtl/approx_pp_sum.sv
// approx_pp_sum: column-truncated partial-product sum over a row range, optional compensation, saturated
module approx_pp_sum import approx_mul_pkg::*; #(
   parameter int WIDTH  = 6,
   parameter int KW     = 4,
   parameter int ROW_LO = 0,
   parameter int ROW_HI = WIDTH - 1,
   parameter bit COMP   = 1'b1
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [1:0]         mode,
   input  logic [KW-1:0]      kc,
   output logic [2*WIDTH-1:0] p
);
   localparam int PW = 2 * WIDTH + 1;
   logic          trunc;
   logic [PW-1:0] sum;
   always_comb begin
      trunc = (mode == MODE_TRUNC || mode == MODE_COMP) && kc != '0;
      sum = '0;
      for (int i = ROW_LO; i <= ROW_HI; i++)
         for (int j = 0; j < WIDTH; j++)
            if (a[i] && b[j] && (!trunc || i + j >= int'(kc)))
               sum = sum + (PW'(1) << (i + j));
      if (COMP && trunc && mode == MODE_COMP)
         sum = sum + (PW'(1) << (kc - KW'(1)));
      p = sum[PW-1] ? '1 : sum[PW-2:0];
   end
endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: valid/ready pipelined approximate multiplier with global stall and delivery counter
module approx_mul_pipe import approx_mul_pkg::*; #(
   parameter int WIDTH  = 6,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4,
   parameter int KW     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [1:0]         in_mode,
   input  logic [KW-1:0]      in_k,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic [TAG_W-1:0]   out_tag,
   output logic [15:0]        out_count
);
   localparam int PW   = 2 * WIDTH;
   localparam int HALF = WIDTH / 2;
   logic [KW-1:0] kc;
   // every stage advances together, so a stalled output freezes the whole pipe
   assign in_ready = !out_valid || out_ready;
   assign kc = KW'(clamp_k(int'(in_k), WIDTH));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) out_count <= '0;
      else if (out_valid && out_ready && out_count != 16'hFFFF) out_count <= out_count + 16'd1;
   if (STAGES == 1) begin : g_one
      logic [PW-1:0] p;
      approx_pp_sum #(.WIDTH(WIDTH), .KW(KW)) u_sum (
         .a(in_a), .b(in_b), .mode(in_mode), .kc(kc), .p(p)
      );
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
         end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
               out_p   <= p;
               out_tag <= in_tag;
            end
         end
   end else begin : g_multi
      logic             v1;
      logic [WIDTH-1:0] a1, b1;
      logic [1:0]       m1;
      logic [KW-1:0]    k1;
      logic [TAG_W-1:0] t1;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            m1 <= '0;
            k1 <= '0;
            t1 <= '0;
         end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
               a1 <= in_a;
               b1 <= in_b;
               m1 <= in_mode;
               k1 <= kc;
               t1 <= in_tag;
            end
         end
      if (STAGES == 2) begin : g_two
         logic [PW-1:0] p;
         approx_pp_sum #(.WIDTH(WIDTH), .KW(KW)) u_sum (
            .a(a1), .b(b1), .mode(m1), .kc(k1), .p(p)
         );
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               out_valid <= 1'b0;
               out_p     <= '0;
               out_tag   <= '0;
            end else if (in_ready) begin
               out_valid <= v1;
               if (v1) begin
                  out_p   <= p;
                  out_tag <= t1;
               end
            end
      end else begin : g_three
         logic             v2;
         logic [PW-1:0]    lo, hi, lo2, hi2;
         logic [TAG_W-1:0] t2;
         logic [PW:0]      tot;
         // low rows can never saturate; saturating the high half early is harmless since sums only grow
         approx_pp_sum #(.WIDTH(WIDTH), .KW(KW), .ROW_LO(0), .ROW_HI(HALF - 1), .COMP(1'b0)) u_lo (
            .a(a1), .b(b1), .mode(m1), .kc(k1), .p(lo)
         );
         approx_pp_sum #(.WIDTH(WIDTH), .KW(KW), .ROW_LO(HALF), .ROW_HI(WIDTH - 1), .COMP(1'b1)) u_hi (
            .a(a1), .b(b1), .mode(m1), .kc(k1), .p(hi)
         );
         assign tot = {1'b0, hi2} + {1'b0, lo2};
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               v2        <= 1'b0;
               lo2       <= '0;
               hi2       <= '0;
               t2        <= '0;
               out_valid <= 1'b0;
               out_p     <= '0;
               out_tag   <= '0;
            end else if (in_ready) begin
               v2        <= v1;
               out_valid <= v2;
               if (v1) begin
                  lo2 <= lo;
                  hi2 <= hi;
                  t2  <= t1;
               end
               if (v2) begin
                  out_p   <= tot[PW] ? '1 : tot[PW-1:0];
                  out_tag <= t2;
               end
            end
      end
   end
endmodule
